wb_core_master: RTL and testbench

//  Wishbone classic (B4, single non-pipelined cycle) initiator that drives the

---
 rtl/neuron_wb_pkg.sv | 20 ++
 rtl/wb_timeout_ctr.sv | 33 +++
 rtl/wb_core_master.sv | 181 ++++++++++++++++++
 tb/tb_wb_core_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_wb_pkg.sv
// Shared definitions for the Wishbone command master that fronts neuron_core.
// Holds the FSM encoding, the neuron_core address map and the default ack timeout.
package neuron_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam logic [31:0] NEURON_CORE_BASE = 32'h3000_0000;
  localparam logic [31:0] NC_OFS_CTRL      = 32'h0000_0000;
  localparam logic [31:0] NC_OFS_WEIGHT    = 32'h0000_0004;
  localparam logic [31:0] NC_OFS_THRESH    = 32'h0000_0008;
  localparam logic [31:0] NC_OFS_LEAK      = 32'h0000_000C;
  localparam logic [31:0] NC_OFS_SPIKE     = 32'h0000_0010;

  localparam int WB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle wait counter: cleared when a command is accepted, counts un-acked cycles,
// and flags the last cycle before the master gives up on the slave.
module wb_timeout_ctr #(
  parameter int TW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_r;

  // Wait-cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {TW{1'b0}};
    end else if (clr) begin
      cnt_r <= {TW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + TW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LIMIT);

endmodule

// File: rtl/wb_core_master.sv
// Wishbone classic initiator: turns one valid/ready command into exactly one bus cycle
// on the neuron_core slave port and returns one response (read data or timeout error).
module wb_core_master
  import neuron_wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = WB_TIMEOUT_DEFAULT,
  parameter int TW      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i,
  output logic            busy
);

  wb_state_e       state_r, state_nxt;
  logic            cmd_ready_r, cmd_ready_nxt;
  logic            rsp_valid_r, rsp_valid_nxt;
  logic [DW-1:0]   rsp_dat_r, rsp_dat_nxt;
  logic            rsp_err_r, rsp_err_nxt;
  logic            cyc_r, cyc_nxt;
  logic            we_r, we_nxt;
  logic [DW/8-1:0] sel_r, sel_nxt;
  logic [AW-1:0]   adr_r, adr_nxt;
  logic [DW-1:0]   dat_r, dat_nxt;
  logic            busy_r, busy_nxt;
  logic            accept_s;
  logic            wait_s;
  logic            expired_s;

  assign accept_s = (state_r == ST_IDLE) && cmd_valid;
  assign wait_s   = (state_r == ST_BUS) && !wbm_ack_i;

  wb_timeout_ctr #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept_s),
    .en      (wait_s),
    .expired (expired_s)
  );

  // State and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= {(DW/8){1'b0}};
      adr_r       <= {AW{1'b0}};
      dat_r       <= {DW{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cmd_ready_r <= cmd_ready_nxt;
      rsp_valid_r <= rsp_valid_nxt;
      rsp_dat_r   <= rsp_dat_nxt;
      rsp_err_r   <= rsp_err_nxt;
      cyc_r       <= cyc_nxt;
      we_r        <= we_nxt;
      sel_r       <= sel_nxt;
      adr_r       <= adr_nxt;
      dat_r       <= dat_nxt;
      busy_r      <= busy_nxt;
    end
  end

  // Next-state decode; ack takes priority over timeout expiry
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = ST_BUS;
        else           state_nxt = ST_IDLE;
      end
      ST_BUS: begin
        if (wbm_ack_i)      state_nxt = ST_RESP;
        else if (expired_s) state_nxt = ST_RESP;
        else                state_nxt = ST_BUS;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
        else           state_nxt = ST_RESP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; bus payload holds its last value when idle
  always_comb begin
    cmd_ready_nxt = cmd_ready_r;
    rsp_valid_nxt = rsp_valid_r;
    rsp_dat_nxt   = rsp_dat_r;
    rsp_err_nxt   = rsp_err_r;
    cyc_nxt       = cyc_r;
    we_nxt        = we_r;
    sel_nxt       = sel_r;
    adr_nxt       = adr_r;
    dat_nxt       = dat_r;
    busy_nxt      = (state_nxt != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_ready_nxt = 1'b0;
          cyc_nxt       = 1'b1;
          we_nxt        = cmd_we;
          sel_nxt       = cmd_sel;
          adr_nxt       = cmd_adr;
          dat_nxt       = cmd_dat;
        end else begin
          cmd_ready_nxt = 1'b1;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          cyc_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_dat_nxt   = we_r ? {DW{1'b0}} : wbm_dat_i;
        end else if (expired_s) begin
          cyc_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_dat_nxt   = {DW{1'b0}};
        end else begin
          cyc_nxt       = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end else begin
          rsp_valid_nxt = 1'b1;
        end
      end
      default: begin
        cyc_nxt       = 1'b0;
        rsp_valid_nxt = 1'b0;
        cmd_ready_nxt = 1'b1;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_dat   = rsp_dat_r;
  assign rsp_err   = rsp_err_r;
  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = sel_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_wb_core_master.sv
// Scoreboard bench for wb_core_master: directed commands push expected responses,
// a monitor pops them on every rsp handshake. TIMEOUT is shrunk to 8 for the timeout cases.
module tb_wb_core_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0;
  logic [31:0] cmd_dat = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        busy;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_core_master #(.AW(32), .DW(32), .TIMEOUT(8), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every accepted response must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer a command in IDLE, let it be taken on the next edge, then check the bus payload
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_dat, input logic exp_err,
                       input bit push);
    rsp_t e;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    if (push) begin
      e.dat = exp_dat; e.err = exp_err;
      exp_q.push_back(e);
    end
    tick;
    cmd_valid = 1'b0;
    check("cyc_up", 64'(wbm_cyc_o), 64'd1);
    check("stb_up", 64'(wbm_stb_o), 64'd1);
    check("cmd_ready_bus", 64'(cmd_ready), 64'd0);
    check("wbm_we", 64'(wbm_we_o), 64'(we));
    check("wbm_adr", 64'(wbm_adr_o), 64'(adr));
    check("wbm_dat", 64'(wbm_dat_o), 64'(dat));
    check("wbm_sel", 64'(wbm_sel_o), 64'(sel));
  endtask

  // Slave model: ack after 'waits' wait states (negative = never); count cycles with cyc high
  task automatic serve(input int waits, input logic [31:0] rdata, input int exp_cycles);
    int cnt;
    cnt = 1;
    wbm_dat_i = rdata;
    wbm_ack_i = (waits == 0);
    while (1) begin
      tick;
      wbm_ack_i = 1'b0;
      if (!wbm_cyc_o || cnt >= 40) break;
      check("stb_eq_cyc", 64'(wbm_stb_o), 64'd1);
      cnt++;
      wbm_ack_i = (waits >= 0) && (cnt == waits + 1);
    end
    check("cyc_cycles", 64'(cnt), 64'(exp_cycles));
    check("rsp_valid_up", 64'(rsp_valid), 64'd1);
  endtask

  // With rsp_ready high the response is taken on the next edge and the FSM is idle again
  task automatic finish_idle;
    tick;
    check("rsp_valid_down", 64'(rsp_valid), 64'd0);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    check("busy_down", 64'(busy), 64'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    check("rst_stb", 64'(wbm_stb_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_adr", 64'(wbm_adr_o), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // 1: zero-wait write
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);
    check("busy_up", 64'(busy), 64'd1);
    serve(0, 32'hFFFF_FFFF, 1);
    finish_idle();

    // 2: read with 5 wait states
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h0000_00A5, 1'b0, 1'b1);
    serve(5, 32'h0000_00A5, 6);
    finish_idle();

    // 3: slave never acks -> timeout after 8 cycles
    issue(1'b0, 32'h3000_0008, 32'h0, 4'h3, 32'h0, 1'b1, 1'b1);
    serve(-1, 32'h1357_9BDF, 8);
    finish_idle();

    // 4: ack on the expiry cycle wins
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'hCAFE_0042, 1'b0, 1'b1);
    serve(7, 32'hCAFE_0042, 8);
    finish_idle();

    // 5: response back-pressure with a new command waiting
    rsp_ready = 1'b0;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h0000_5A5A, 1'b0, 1'b1);
    serve(2, 32'h0000_5A5A, 3);
    cmd_we = 1'b1; cmd_adr = 32'h3000_0000; cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'h1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_dat", 64'(rsp_dat), 64'h0000_5A5A);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp_no_cyc", 64'(wbm_cyc_o), 64'd0);
    end
    begin
      rsp_t e;
      e.dat = 32'h0; e.err = 1'b0;
      exp_q.push_back(e);
    end
    rsp_ready = 1'b1;
    tick;
    check("bp_cmd_ready_after", 64'(cmd_ready), 64'd1);
    check("bp_cyc_still_low", 64'(wbm_cyc_o), 64'd0);
    tick;
    cmd_valid = 1'b0;
    check("bp_next_cyc", 64'(wbm_cyc_o), 64'd1);
    check("bp_next_adr", 64'(wbm_adr_o), 64'h3000_0000);
    check("bp_next_sel", 64'(wbm_sel_o), 64'h1);
    serve(0, 32'h0, 1);
    finish_idle();

    // 6: reset in the middle of a bus cycle, then a stray ack while idle
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
    tick; tick; tick;
    check("mid_bus_cyc", 64'(wbm_cyc_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_cyc", 64'(wbm_cyc_o), 64'd0);
    check("async_stb", 64'(wbm_stb_o), 64'd0);
    check("async_rsp_valid", 64'(rsp_valid), 64'd0);
    tick;
    rst_n = 1'b1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    tick; tick;
    wbm_ack_i = 1'b0;
    check("stray_rsp_valid", 64'(rsp_valid), 64'd0);
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_cmd_ready", 64'(cmd_ready), 64'd1);

    // recovery: a normal read still works after reset
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
    serve(1, 32'h1234_5678, 2);
    finish_idle();

    tick;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
